inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch front end of the OpenMIPS pipeline: owns the program counter, drives the instruction ROM's chip-enable and byte address, and registers the returned instruction with its PC into the IF/ID pipeline register for decode. It is the initiator on the ROM fetch interface; the ROM answers combinationally in the same cycle. It honours the pipeline stall vector, branch redirects from ID, and exception flush redirects from the control unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; synchronous and active-high (`RstEnable`).
- stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID.
- flush  in  1  exception flush from control unit.
- new_pc  in  32  exception handler address, valid with flush.
- branch_flag_i  in  1  taken branch/jump from ID.
- branch_target_address_i  in  32  branch/jump target from ID.
- rom_ce_o  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- rom_addr_o  out  32  fetch byte address, equal to current PC.
- rom_inst_i  in  32  instruction word from ROM, same cycle.
- id_pc_o  out  32  PC of instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- perf_fetch_o  out  32  fetched-instruction count (only with IFETCH_PERF_CNT_EN).
- perf_bubble_o  out  32  bubble count (only with IFETCH_PERF_CNT_EN).

## Operation
- ce register: rst → 0; otherwise 1 on the next edge. rom_ce_o is the register output.
- PC register, priority per edge:
  - ce = 0 → PC ← RESET_PC.
  - flush → PC ← new_pc.
  - stall[0] → hold.
  - branch_flag_i → PC ← {branch_target_address_i[31:2], 2'b00}.
  - else PC ← PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- PC[1:0] are always 00; new_pc is used as given (control unit guarantees alignment).
- IF/ID register, priority per edge:
  - rst or flush → id_pc_o, id_inst_o ← `ZeroWord`.
  - stall[1] = 1 and stall[2] = 0 → `ZeroWord` bubble (NOP into ID).
  - stall[1] = 0 → id_pc_o ← PC, id_inst_o ← rom_inst_i.
  - else hold.
- With rom_ce_o = 0 the ROM returns `ZeroWord`; a capture in that cycle loads a NOP at PC RESET_PC.
- Branch delay slot: the instruction fetched in the cycle branch_flag_i is high is captured normally. No squash.
- Simultaneous flush and branch: flush wins. Flush during stall: flush wins for both registers.
- rst asserted mid-run: all registers reach reset values at that edge; the first fetch of RESET_PC is issued the edge after rst deasserts.

## Timing
- Reset values: rom_ce_o = 0, rom_addr_o = RESET_PC, id_pc_o = 0, id_inst_o = 0, perf counters = 0.
- Fetch latency: PC issued cycle N, instruction visible on id_inst_o after edge N+1.
- Redirect latency: branch or flush sampled at edge N; target appears on rom_addr_o after edge N.
- No combinational path from any input to rom_addr_o or rom_ce_o.

## Configuration
- IFETCH_PERF_CNT_EN defined:
  - perf_fetch_o increments on each IF/ID capture with rom_ce_o = 1.
  - perf_bubble_o increments on each bubble or flush of IF/ID.
  - Both counters wrap at 2^32 and clear on rst.
- Undefined: both ports and both counters are absent.

## Structure
- defines.v holds the shared constants: `RstEnable`, `ChipEnable`, `ChipDisable`, `ZeroWord`, `InstAddrBus`, `InstBus`, `StallBus`, plus the `RESET_PC` default.
- The IF/ID register is one sub-module, `if_id`. It has the stall/flush/bubble rules and the perf counters.
- PC and ce logic stay in inst_fetch.

## Test plan
- Reset release, ROM returning word = 4×index: rom_addr_o 0, 4, 8 on successive cycles; id_inst_o = 0, then 0, then 4 one cycle behind.
- stall = 6'b000011 for 2 cycles at PC 0x10: rom_addr_o holds 0x10; id_inst_o = 0 (bubble) both cycles; resumes at 0x14.
- stall = 6'b000111: PC and IF/ID both hold their values unchanged.
- branch_flag_i with target 0x103 at PC 0x20: delay slot 0x24 is captured; next PC = 0x100.
- flush with new_pc = 0x40 together with branch_flag_i: next PC = 0x40; IF/ID cleared; perf_bubble_o += 1 when macro defined.
- PC = 0xFFFF_FFFC, no stall: next PC = 0x0000_0000.
- rst pulse mid-run: all outputs at reset values on the next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, IF/ID action encoding and the
// helper that resolves the IF/ID register's per-edge action.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int STALL_W     = 6;

    // Stall vector bit positions
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [INST_W-1:0]      ZERO_WORD        = '0;
    localparam logic [INST_ADDR_W-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [2:0] {
        IFID_RESET,
        IFID_FLUSH,
        IFID_BUBBLE,
        IFID_LOAD,
        IFID_HOLD
    } ifid_op_e;

    // Reset beats flush, flush beats any stall combination.
    function automatic ifid_op_e ifid_op(
        input logic rst,
        input logic flush,
        input logic stall_if,
        input logic stall_id
    );
        ifid_op_e op;
        if (rst == RST_ENABLE)
            op = IFID_RESET;
        else if (flush)
            op = IFID_FLUSH;
        else if (stall_if && !stall_id)
            op = IFID_BUBBLE;
        else if (!stall_if)
            op = IFID_LOAD;
        else
            op = IFID_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/inst_fetch_if_id.sv
// if_id: IF/ID pipeline register with stall, bubble and flush rules.
// Ports: clk, rst (sync, active-high), flush, stall vector, ce_i (ROM
// enable of the fetch being captured), pc_i/inst_i in, id_pc_o/id_inst_o
// out; perf_fetch_o/perf_bubble_o only when IFETCH_PERF_CNT_EN is defined.
import inst_fetch_pkg::*;

module if_id (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   ce_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_o,
    output logic [31:0]            perf_bubble_o
`endif
);

    ifid_op_e op;
    logic     unused_stall;

    assign op = ifid_op(rst, flush, stall[STALL_IF], stall[STALL_ID]);

    // PC-hold and later-stage bits belong to other stages
    assign unused_stall = ^{stall[STALL_W-1:3], stall[STALL_PC]};

    always_ff @(posedge clk) begin
        unique case (op)
            IFID_RESET, IFID_FLUSH, IFID_BUBBLE: begin
                id_pc_o   <= ZERO_WORD;
                id_inst_o <= ZERO_WORD;
            end
            IFID_LOAD: begin
                id_pc_o   <= pc_i;
                id_inst_o <= inst_i;
            end
            default: begin
                id_pc_o   <= id_pc_o;
                id_inst_o <= id_inst_o;
            end
        endcase
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        unique case (op)
            IFID_RESET: begin
                perf_fetch_o  <= '0;
                perf_bubble_o <= '0;
            end
            IFID_FLUSH, IFID_BUBBLE: begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
            IFID_LOAD: begin
                // Captures while the ROM is disabled are NOPs, not fetches
                if (ce_i == CHIP_ENABLE)
                    perf_fetch_o <= perf_fetch_o + 32'd1;
            end
            default: begin
                perf_fetch_o  <= perf_fetch_o;
                perf_bubble_o <= perf_bubble_o;
            end
        endcase
    end
`else
    logic unused_ce;
    assign unused_ce = ce_i;
`endif

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC/ROM chip-enable owner feeding the IF/ID register.
// Ports: clk, rst (sync, active-high), stall[5:0], flush/new_pc,
// branch_flag_i/branch_target_address_i, ROM rom_ce_o/rom_addr_o/
// rom_inst_i, IF/ID id_pc_o/id_inst_o. Optional IFETCH_PERF_CNT_EN adds
// perf_fetch_o/perf_bubble_o.
import inst_fetch_pkg::*;

module inst_fetch #(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    output logic                   rom_ce_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0]      rom_inst_i,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_o,
    output logic [31:0]            perf_bubble_o
`endif
);

    logic                   ce_q;
    logic [INST_ADDR_W-1:0] pc_q;
    logic                   unused_tgt;

    // Branch targets are forced onto a word boundary
    assign unused_tgt = ^branch_target_address_i[1:0];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            ce_q <= CHIP_DISABLE;
        else
            ce_q <= CHIP_ENABLE;
    end

    // rst is folded in so a mid-run reset parks the PC at the same edge
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || ce_q == CHIP_DISABLE)
            pc_q <= RESET_PC;
        else if (flush)
            pc_q <= new_pc;
        else if (stall[STALL_PC])
            pc_q <= pc_q;
        else if (branch_flag_i)
            pc_q <= {branch_target_address_i[31:2], 2'b00};
        else
            pc_q <= pc_q + 32'd4;
    end

    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q;

    if_id u_if_id (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .stall        (stall),
        .ce_i         (ce_q),
        .pc_i         (pc_q),
        .inst_i       (rom_inst_i),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_o (perf_fetch_o),
        .perf_bubble_o(perf_bubble_o)
`endif
    );

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a behavioural
// ROM and reference model; directed test-plan steps then random traffic.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_bubble_o;
`endif

    int compared   = 0;
    int mismatched = 0;
    int rom_mode   = 0;

    always #5 clk = ~clk;

    // mode 0: word = 4*index (= address); mode 1: scrambled
    function automatic logic [31:0] rom_word(input logic [31:0] a, input int m);
        return (m == 0) ? a : {a[15:0], ~a[31:16]};
    endfunction

    assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o, rom_mode) : 32'h0;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .flush                  (flush),
        .new_pc                 (new_pc),
        .branch_flag_i          (branch_flag_i),
        .branch_target_address_i(branch_target_address_i),
        .rom_ce_o               (rom_ce_o),
        .rom_addr_o             (rom_addr_o),
        .rom_inst_i             (rom_inst_i),
        .id_pc_o                (id_pc_o),
        .id_inst_o              (id_inst_o)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_o           (perf_fetch_o),
        .perf_bubble_o          (perf_bubble_o)
`endif
    );

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] idpc;
        logic [31:0] idinst;
        logic [31:0] pf;
        logic [31:0] pb;
    } exp_t;

    exp_t q[$];

    // Reference model state: what the outputs should be right now
    logic        m_ce = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_idpc = '0;
    logic [31:0] m_idinst = '0;
    logic [31:0] m_pf = '0;
    logic [31:0] m_pb = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the post-edge expectation
    task automatic step(input logic r, input logic [5:0] s, input logic f,
                        input logic [31:0] np, input logic b, input logic [31:0] t);
        logic [31:0] rom;
        logic [31:0] npc;
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; new_pc = np;
        branch_flag_i = b; branch_target_address_i = t;
        rom = m_ce ? rom_word(m_pc, rom_mode) : 32'h0;
        if (r) begin
            m_idpc = 0; m_idinst = 0; m_pf = 0; m_pb = 0;
        end else if (f || (s[1] && !s[2])) begin
            m_idpc = 0; m_idinst = 0; m_pb = m_pb + 1;
        end else if (!s[1]) begin
            m_idpc = m_pc; m_idinst = rom;
            if (m_ce) m_pf = m_pf + 1;
        end
        if (r || !m_ce) npc = RST_PC;
        else if (f) npc = np;
        else if (s[0]) npc = m_pc;
        else if (b) npc = t & 32'hFFFF_FFFC;
        else npc = m_pc + 32'd4;
        m_pc = npc;
        m_ce = !r;
        e.ce = m_ce; e.addr = m_pc; e.idpc = m_idpc; e.idinst = m_idinst;
        e.pf = m_pf; e.pb = m_pb;
        q.push_back(e);
    endtask

    // Step, then wait until the edge has settled for directed checks
    task automatic go(input logic r, input logic [5:0] s, input logic f,
                      input logic [31:0] np, input logic b, input logic [31:0] t);
        step(r, s, f, np, b, t);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every expected post-edge state
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rom_ce",  {31'b0, rom_ce_o}, {31'b0, e.ce});
                chk("rom_addr", rom_addr_o, e.addr);
                chk("id_pc",    id_pc_o,    e.idpc);
                chk("id_inst",  id_inst_o,  e.idinst);
`ifdef IFETCH_PERF_CNT_EN
                chk("perf_fetch",  perf_fetch_o,  e.pf);
                chk("perf_bubble", perf_bubble_o, e.pb);
`endif
            end
        end
    end

    initial begin
        logic [5:0] stab [10];
        stab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h03, 6'h07, 6'h0F, 6'h02, 6'h06, 6'h01};

        // Reset
        go(1, 0, 0, 0, 0, 0);
        go(1, 0, 0, 0, 0, 0);
        chk("rst_ce", {31'b0, rom_ce_o}, 32'd0);
        chk("rst_addr", rom_addr_o, RST_PC);
        chk("rst_inst", id_inst_o, 32'd0);

        // Release: 0, 4, 8 with IF/ID 0, 0, 4
        go(0, 0, 0, 0, 0, 0);
        chk("rel_addr0", rom_addr_o, 32'h0);
        chk("rel_inst0", id_inst_o, 32'h0);
        go(0, 0, 0, 0, 0, 0);
        chk("rel_addr1", rom_addr_o, 32'h4);
        chk("rel_inst1", id_inst_o, 32'h0);
        go(0, 0, 0, 0, 0, 0);
        chk("rel_addr2", rom_addr_o, 32'h8);
        chk("rel_inst2", id_inst_o, 32'h4);
        go(0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0);
        chk("at_10", rom_addr_o, 32'h10);

        // PC+IF stall: bubbles, PC held
        go(0, 6'b000011, 0, 0, 0, 0);
        chk("stl_addr0", rom_addr_o, 32'h10);
        chk("stl_inst0", id_inst_o, 32'h0);
        go(0, 6'b000011, 0, 0, 0, 0);
        chk("stl_addr1", rom_addr_o, 32'h10);
        chk("stl_inst1", id_inst_o, 32'h0);
        go(0, 0, 0, 0, 0, 0);
        chk("resume", rom_addr_o, 32'h14);

        // Full hold
        go(0, 6'b000111, 0, 0, 0, 0);
        chk("hold_addr", rom_addr_o, 32'h14);
        chk("hold_pc",   id_pc_o,    32'h10);
        chk("hold_inst", id_inst_o,  32'h10);

        // Branch at 0x20 resolved while delay slot 0x24 is fetched
        go(0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0);
        chk("pre_br", rom_addr_o, 32'h24);
        go(0, 0, 0, 0, 1, 32'h103);
        chk("br_addr", rom_addr_o, 32'h100);
        chk("br_slot", id_pc_o, 32'h24);

        // Flush beats branch
        go(0, 6'b000111, 1, 32'h40, 1, 32'h200);
        chk("fl_addr", rom_addr_o, 32'h40);
        chk("fl_pc",   id_pc_o, 32'h0);
        chk("fl_inst", id_inst_o, 32'h0);

        // Wrap
        go(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        go(0, 0, 0, 0, 0, 0);
        chk("wrap", rom_addr_o, 32'h0);
        chk("wrap_pc", id_pc_o, 32'hFFFF_FFFC);

        // Mid-run reset
        go(0, 0, 0, 0, 0, 0);
        go(1, 0, 0, 0, 0, 0);
        chk("mrst_ce", {31'b0, rom_ce_o}, 32'd0);
        chk("mrst_addr", rom_addr_o, RST_PC);
        chk("mrst_pc", id_pc_o, 32'h0);
        go(0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0);
        chk("mrst_next", rom_addr_o, 32'h4);

        // Random traffic
        rom_mode = 1;
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 60) == 0,
                 stab[$urandom % 10],
                 ($urandom % 12) == 0,
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom % 5) == 0,
                 $urandom);
        end
        step(0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #3;
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
